row_mem_scatter: RTL

- Parametrised successor to the single-config activation/weight row-memory loader.
- Accepts two independent valid/ready byte streams (activations, weights) from the act/weight controller.
- Scatters each byte to one of many per-row SRAMs (one-hot en/we plus local address) for the systolic array.
- Supports multiple input channels per pass, any K up to K_MAX, strict handshakes, configuration checking and optional on-the-fly zero padding.

---
 rtl/row_mem_scatter_if.sv | 38 +++
 rtl/row_mem_scatter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_mem_scatter_if.sv
// row_mem_scatter_if: activation/weight input streams and row-memory write buses.
// slave = scatter block side, master = stream producer / memory side.
interface row_mem_scatter_if #(
  parameter int INPUT_BW       = 8,
  parameter int IA_ADDR_W      = 6,
  parameter int W_ADDR_W       = 8,
  parameter int NUM_IA_ROW_MEM = 96,
  parameter int NUM_W_ROW_MEM  = 15
);
  logic                      act_valid;
  logic [INPUT_BW-1:0]       act_data;
  logic                      act_ready;
  logic                      w_valid;
  logic [INPUT_BW-1:0]       w_data;
  logic                      w_ready;
  logic [INPUT_BW-1:0]       ia_wdata;
  logic [IA_ADDR_W-1:0]      ia_waddr;
  logic [NUM_IA_ROW_MEM-1:0] ia_en;
  logic [NUM_IA_ROW_MEM-1:0] ia_we;
  logic [INPUT_BW-1:0]       w_wdata;
  logic [W_ADDR_W-1:0]       w_waddr;
  logic [NUM_W_ROW_MEM-1:0]  w_en;
  logic [NUM_W_ROW_MEM-1:0]  w_we;

  modport slave (
    input  act_valid, act_data, w_valid, w_data,
    output act_ready, w_ready,
    output ia_wdata, ia_waddr, ia_en, ia_we,
    output w_wdata, w_waddr, w_en, w_we
  );

  modport master (
    output act_valid, act_data, w_valid, w_data,
    input  act_ready, w_ready,
    input  ia_wdata, ia_waddr, ia_en, ia_we,
    input  w_wdata, w_waddr, w_en, w_we
  );
endinterface

// File: rtl/row_mem_scatter.sv
// row_mem_scatter: scatters activation/weight byte streams into per-row SRAMs.
// Define ROW_MEM_SCATTER_ZERO_PAD_EN to generate border zero writes in-block.
module row_mem_scatter #(
  parameter int INPUT_BW       = 8,
  parameter int DIM_W          = 6,
  parameter int K_MAX          = 5,
  parameter int IC_PAR         = 3,
  parameter int NUM_IA_ROW_MEM = 96,
  parameter int IA_ADDR_W      = 6,
  parameter int NUM_W_ROW_MEM  = 15,
  parameter int W_ADDR_W       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  input  logic [2:0]       cfg_k,
  input  logic [1:0]       cfg_ic,
  input  logic [DIM_W-1:0] cfg_oc,
  input  logic [DIM_W-1:0] cfg_img_h,
  input  logic [DIM_W-1:0] cfg_img_w,
  row_mem_scatter_if.slave bus
);

  localparam int ROWS  = NUM_IA_ROW_MEM / IC_PAR;
  localparam int CW    = DIM_W + 1;
  localparam int IAR_W = $clog2(NUM_IA_ROW_MEM);
  localparam int WR_W  = $clog2(NUM_W_ROW_MEM);
  localparam int WA_W  = W_ADDR_W + 1;
  localparam logic [NUM_IA_ROW_MEM-1:0] IA_ONE = NUM_IA_ROW_MEM'(1);
  localparam logic [NUM_W_ROW_MEM-1:0]  W_ONE  = NUM_W_ROW_MEM'(1);

  typedef enum logic [1:0] {IDLE, CHECK, LOAD, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]       k_q;
  logic [1:0]       ic_q;
  logic [DIM_W-1:0] oc_q, h_q, w_q;
  logic [CW-1:0]    ph_q, pw_q, ph_c, pw_c;
  logic             err_q, cfg_bad;

  logic [1:0]       a_ic;
  logic [CW-1:0]    a_r, a_c;
  logic [IAR_W-1:0] a_base, a_row;
  logic             a_fin, a_run, a_pad, a_adv;
  logic             a_last_c, a_last_r, a_last_ic;

  logic [1:0]       w_ic;
  logic [DIM_W-1:0] w_oc;
  logic [2:0]       w_kr, w_kc;
  logic [WR_W-1:0]  w_rbase, w_row;
  logic [WA_W-1:0]  w_abase, w_addr;
  logic             w_fin, w_run, w_adv;
  logic             w_last_kc, w_last_kr, w_last_oc, w_last_ic;

  assign ph_c = CW'(h_q) + CW'(k_q) - CW'(1);
  assign pw_c = CW'(w_q) + CW'(k_q) - CW'(1);

  assign cfg_bad = (k_q == 3'd0)
                || (32'(k_q) > 32'(K_MAX))
                || (ic_q == 2'd0)
                || (32'(ic_q) > 32'(IC_PAR))
                || (oc_q == '0)
                || (32'(ph_c) > 32'(ROWS))
                || (32'(pw_c) > 32'(1 << IA_ADDR_W))
                || (32'(oc_q) * 32'(k_q) > 32'(1 << W_ADDR_W));

`ifdef ROW_MEM_SCATTER_ZERO_PAD_EN
  logic [CW-1:0] pt;
  // top/left border is (K-1)/2; bottom/right takes the remainder
  assign pt    = CW'((k_q - 3'd1) >> 1);
  assign a_pad = (a_r < pt) || (a_r >= pt + CW'(h_q))
              || (a_c < pt) || (a_c >= pt + CW'(w_q));
`else
  assign a_pad = 1'b0;
`endif

  assign a_run = (state == LOAD) && !a_fin;
  assign a_adv = a_run && (a_pad || bus.act_valid);
  assign w_run = (state == LOAD) && !w_fin;
  assign w_adv = w_run && bus.w_valid;

  assign bus.act_ready = a_run && !a_pad;
  assign bus.w_ready   = w_run;

  assign a_last_c  = a_c == pw_q - CW'(1);
  assign a_last_r  = a_r == ph_q - CW'(1);
  assign a_last_ic = a_ic == ic_q - 2'd1;
  assign a_row     = a_base + IAR_W'(a_r);

  assign w_last_kc = w_kc == k_q - 3'd1;
  assign w_last_kr = w_kr == k_q - 3'd1;
  assign w_last_oc = w_oc == oc_q - DIM_W'(1);
  assign w_last_ic = w_ic == ic_q - 2'd1;
  assign w_row     = w_rbase + WR_W'(w_kr);
  assign w_addr    = w_abase + WA_W'(w_kc);

  assign busy    = (state == CHECK) || (state == LOAD);
  assign done    = state == DONE;
  assign cfg_err = done && err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = cfg_bad ? DONE : LOAD;
      LOAD:    if (a_fin && w_fin) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_q   <= '0;
      ic_q  <= '0;
      oc_q  <= '0;
      h_q   <= '0;
      w_q   <= '0;
      ph_q  <= '0;
      pw_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        k_q  <= cfg_k;
        ic_q <= cfg_ic;
        oc_q <= cfg_oc;
        h_q  <= cfg_img_h;
        w_q  <= cfg_img_w;
      end
      if (state == CHECK) begin
        err_q <= cfg_bad;
        ph_q  <= ph_c;
        pw_q  <= pw_c;
      end
    end
  end

  // activation walk: ic -> row -> column
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_ic   <= '0;
      a_r    <= '0;
      a_c    <= '0;
      a_base <= '0;
      a_fin  <= 1'b0;
    end else if (state == CHECK) begin
      a_ic   <= '0;
      a_r    <= '0;
      a_c    <= '0;
      a_base <= '0;
      a_fin  <= (ph_c == '0) || (pw_c == '0);
    end else if (a_adv) begin
      if (!a_last_c) a_c <= a_c + CW'(1);
      else begin
        a_c <= '0;
        if (!a_last_r) a_r <= a_r + CW'(1);
        else begin
          a_r <= '0;
          if (!a_last_ic) begin
            a_ic   <= a_ic + 2'd1;
            a_base <= a_base + IAR_W'(ROWS);
          end else a_fin <= 1'b1;
        end
      end
    end
  end

  // weight walk: ic -> oc -> kernel row -> kernel column
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_ic    <= '0;
      w_oc    <= '0;
      w_kr    <= '0;
      w_kc    <= '0;
      w_rbase <= '0;
      w_abase <= '0;
      w_fin   <= 1'b0;
    end else if (state == CHECK) begin
      w_ic    <= '0;
      w_oc    <= '0;
      w_kr    <= '0;
      w_kc    <= '0;
      w_rbase <= '0;
      w_abase <= '0;
      w_fin   <= 1'b0;
    end else if (w_adv) begin
      if (!w_last_kc) w_kc <= w_kc + 3'd1;
      else begin
        w_kc <= '0;
        if (!w_last_kr) w_kr <= w_kr + 3'd1;
        else begin
          w_kr <= '0;
          if (!w_last_oc) begin
            w_oc    <= w_oc + DIM_W'(1);
            w_abase <= w_abase + WA_W'(k_q);
          end else begin
            w_oc    <= '0;
            w_abase <= '0;
            if (!w_last_ic) begin
              w_ic    <= w_ic + 2'd1;
              w_rbase <= w_rbase + WR_W'(k_q);
            end else w_fin <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.ia_en    <= '0;
      bus.ia_we    <= '0;
      bus.ia_wdata <= '0;
      bus.ia_waddr <= '0;
      bus.w_en     <= '0;
      bus.w_we     <= '0;
      bus.w_wdata  <= '0;
      bus.w_waddr  <= '0;
    end else begin
      bus.ia_en <= a_adv ? (IA_ONE << a_row) : '0;
      bus.ia_we <= a_adv ? (IA_ONE << a_row) : '0;
      if (a_adv) begin
        bus.ia_wdata <= a_pad ? '0 : bus.act_data;
        bus.ia_waddr <= IA_ADDR_W'(a_c);
      end
      bus.w_en <= w_adv ? (W_ONE << w_row) : '0;
      bus.w_we <= w_adv ? (W_ONE << w_row) : '0;
      if (w_adv) begin
        bus.w_wdata <= bus.w_data;
        bus.w_waddr <= W_ADDR_W'(w_addr);
      end
    end
  end

endmodule
